// File: rtl/pe_cube_result_collector_if.sv
// pe_cube_result_collector_if: capture bus, drain stream and status of the pe_cube result collector
// Capture side : iResult (8 bits per lane), iResultValid (one bit per lane)
// Drain side   : oData, oLane, oLast, oValid with iReady handshake
// Status side  : oOverflow, oDropCount, oIdle, iClearOverflow
// master = environment that feeds results and consumes the stream, slave = the collector
interface pe_cube_result_collector_if #(
   parameter int LANES = 27,
   parameter int LW    = $clog2(LANES)
);
   logic [8*LANES-1:0] iResult;
   logic [LANES-1:0]   iResultValid;
   logic [7:0]         oData;
   logic [LW-1:0]      oLane;
   logic               oLast;
   logic               oValid;
   logic               iReady;
   logic               oOverflow;
   logic               iClearOverflow;
   logic [15:0]        oDropCount;
   logic               oIdle;
   modport master (
      output iResult, iResultValid, iReady, iClearOverflow,
      input  oData, oLane, oLast, oValid, oOverflow, oDropCount, oIdle
   );
   modport slave (
      input  iResult, iResultValid, iReady, iClearOverflow,
      output oData, oLane, oLast, oValid, oOverflow, oDropCount, oIdle
   );
endinterface

// File: rtl/pe_cube_result_collector.sv
// pe_cube_result_collector: ping-pong snapshot buffer draining pe_cube results one lane byte per handshake
// iClk : clock, rising edge
// iRst : synchronous active-high reset
// bus  : slave view of pe_cube_result_collector_if (capture bus, drain stream, overflow status)
module pe_cube_result_collector #(
   parameter int ARRAY_NUM = 3,
   parameter int BLOCK_NUM = 3,
   parameter int CUBE_NUM  = 3
) (
   input  logic                           iClk,
   input  logic                           iRst,
   pe_cube_result_collector_if.slave      bus
);
   localparam int LANES = ARRAY_NUM * BLOCK_NUM * CUBE_NUM;
   localparam int LW    = $clog2(LANES);

   logic [LANES-1:0]   mask_q [2];
   logic [LANES-1:0]   mask_d [2];
   logic [8*LANES-1:0] data_q [2];
   logic [8*LANES-1:0] data_d [2];
   logic [1:0]         full_q, full_d;
   logic               wp_q, wp_d, rp_q, rp_d;
   logic               ovf_q, ovf_d;
   logic [15:0]        cnt_q, cnt_d;

   logic [LANES-1:0]   cur_mask;
   logic [LW-1:0]      lane;
   logic               valid, last, xfer, any, cap, drop;

   assign cur_mask = mask_q[rp_q];
   assign valid    = full_q[rp_q];
   // one bit left: clearing the lowest set bit leaves nothing
   assign last     = valid && ((cur_mask & (cur_mask - 1'b1)) == '0);
   assign xfer     = valid && bus.iReady;
   assign any      = |bus.iResultValid;
   // fullness is judged on registered state, so a bank freed this cycle is not reused until next cycle
   assign cap      = any && !full_q[wp_q];
   assign drop     = any && full_q[wp_q];

   always_comb begin
      lane = '0;
      for (int k = LANES - 1; k >= 0; k--)
         if (cur_mask[k]) lane = LW'(k);
   end

   always_comb begin
      mask_d = mask_q;
      data_d = data_q;
      full_d = full_q;
      wp_d   = wp_q;
      rp_d   = rp_q;
      ovf_d  = ovf_q;
      cnt_d  = cnt_q;
      // capture and drain always target different banks: one needs full, the other needs empty
      if (xfer) begin
         mask_d[rp_q][lane] = 1'b0;
         if (last) begin
            full_d[rp_q] = 1'b0;
            rp_d         = ~rp_q;
         end
      end
      if (cap) begin
         mask_d[wp_q] = bus.iResultValid;
         data_d[wp_q] = bus.iResult;
         full_d[wp_q] = 1'b1;
         wp_d         = ~wp_q;
      end
      if (drop) begin
         ovf_d = 1'b1;
         cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
      end
      if (bus.iClearOverflow) begin
         ovf_d = 1'b0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         mask_q <= '{default: '0};
         data_q <= '{default: '0};
         full_q <= '0;
         wp_q   <= 1'b0;
         rp_q   <= 1'b0;
         ovf_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         mask_q <= mask_d;
         data_q <= data_d;
         full_q <= full_d;
         wp_q   <= wp_d;
         rp_q   <= rp_d;
         ovf_q  <= ovf_d;
         cnt_q  <= cnt_d;
      end
   end

   // presented fields read zero while nothing is valid, so stale bank bytes never leak out
   assign bus.oValid     = valid;
   assign bus.oLane      = valid ? lane : '0;
   assign bus.oData      = valid ? data_q[rp_q][{lane, 3'b000} +: 8] : 8'h00;
   assign bus.oLast      = last;
   assign bus.oOverflow  = ovf_q;
   assign bus.oDropCount = cnt_q;
   assign bus.oIdle      = !full_q[0] && !full_q[1];
endmodule

// File: tb/tb_pe_cube_result_collector.sv
// tb_pe_cube_result_collector: directed self-checking bench for pe_cube_result_collector
module tb_pe_cube_result_collector;
   logic clk, rst;
   int   passed, total;
   logic [8*27-1:0] res;

   pe_cube_result_collector_if #(.LANES(27), .LW(5)) b ();
   pe_cube_result_collector dut (.iClk(clk), .iRst(rst), .bus(b.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [26:0] m);
      b.iResultValid = m;
      b.iResult      = res;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      b.iResultValid = '0; b.iResult = '0; b.iReady = 1'b0; b.iClearOverflow = 1'b0;
      tick; tick;
      rst = 1'b0;
      total++; if (b.oValid !== 1'b0) $display("FAIL rst_valid got %0d exp 0", b.oValid); else passed++;
      total++; if (b.oData !== 8'h00) $display("FAIL rst_data got %h exp 00", b.oData); else passed++;
      total++; if (b.oLane !== 5'd0) $display("FAIL rst_lane got %0d exp 0", b.oLane); else passed++;
      total++; if (b.oLast !== 1'b0) $display("FAIL rst_last got %0d exp 0", b.oLast); else passed++;
      total++; if (b.oOverflow !== 1'b0) $display("FAIL rst_ovf got %0d exp 0", b.oOverflow); else passed++;
      total++; if (b.oDropCount !== 16'd0) $display("FAIL rst_cnt got %0d exp 0", b.oDropCount); else passed++;
      total++; if (b.oIdle !== 1'b1) $display("FAIL rst_idle got %0d exp 1", b.oIdle); else passed++;
   endtask

   task automatic test_single;
      b.iReady = 1'b1;
      res = '0; res[7:0] = 8'h11; res[23:16] = 8'h22;
      drive(27'h5);
      tick;
      b.iResultValid = '0;
      total++; if (b.oValid !== 1'b1) $display("FAIL single_v1 got %0d exp 1", b.oValid); else passed++;
      total++; if (b.oLane !== 5'd0) $display("FAIL single_lane1 got %0d exp 0", b.oLane); else passed++;
      total++; if (b.oData !== 8'h11) $display("FAIL single_data1 got %h exp 11", b.oData); else passed++;
      total++; if (b.oLast !== 1'b0) $display("FAIL single_last1 got %0d exp 0", b.oLast); else passed++;
      tick;
      total++; if (b.oLane !== 5'd2) $display("FAIL single_lane2 got %0d exp 2", b.oLane); else passed++;
      total++; if (b.oData !== 8'h22) $display("FAIL single_data2 got %h exp 22", b.oData); else passed++;
      total++; if (b.oLast !== 1'b1) $display("FAIL single_last2 got %0d exp 1", b.oLast); else passed++;
      tick;
      total++; if (b.oValid !== 1'b0) $display("FAIL single_v3 got %0d exp 0", b.oValid); else passed++;
      total++; if (b.oIdle !== 1'b1) $display("FAIL single_idle got %0d exp 1", b.oIdle); else passed++;
   endtask

   task automatic test_backpressure;
      b.iReady = 1'b0;
      res = '0; res[7:0] = 8'h11; res[23:16] = 8'h22;
      drive(27'h5);
      tick;
      b.iResultValid = '0;
      for (int i = 0; i < 3; i++) begin
         total++; if (b.oValid !== 1'b1 || b.oLane !== 5'd0 || b.oData !== 8'h11 || b.oLast !== 1'b0)
            $display("FAIL bp_hold%0d got v=%0d lane=%0d data=%h last=%0d exp v=1 lane=0 data=11 last=0", i, b.oValid, b.oLane, b.oData, b.oLast);
         else passed++;
         if (i < 2) tick;
      end
      b.iReady = 1'b1;
      tick;
      total++; if (b.oLane !== 5'd2 || b.oData !== 8'h22 || b.oLast !== 1'b1)
         $display("FAIL bp_lane2 got lane=%0d data=%h last=%0d exp lane=2 data=22 last=1", b.oLane, b.oData, b.oLast);
      else passed++;
      tick;
      total++; if (b.oIdle !== 1'b1) $display("FAIL bp_idle got %0d exp 1", b.oIdle); else passed++;
   endtask

   task automatic test_back_to_back;
      b.iReady = 1'b1;
      res = '0; res[15:8] = 8'hA1; res[31:24] = 8'hA3;
      drive(27'b1010);
      tick;
      total++; if (b.oLane !== 5'd1 || b.oData !== 8'hA1 || b.oLast !== 1'b0)
         $display("FAIL b2b_lane1 got lane=%0d data=%h last=%0d exp lane=1 data=a1 last=0", b.oLane, b.oData, b.oLast);
      else passed++;
      res = '0; res[215:208] = 8'h7F;
      drive(27'h4000000);
      tick;
      b.iResultValid = '0;
      total++; if (b.oLane !== 5'd3 || b.oData !== 8'hA3 || b.oLast !== 1'b1)
         $display("FAIL b2b_lane3 got lane=%0d data=%h last=%0d exp lane=3 data=a3 last=1", b.oLane, b.oData, b.oLast);
      else passed++;
      tick;
      total++; if (b.oValid !== 1'b1 || b.oLane !== 5'd26 || b.oData !== 8'h7F || b.oLast !== 1'b1)
         $display("FAIL b2b_lane26 got v=%0d lane=%0d data=%h last=%0d exp v=1 lane=26 data=7f last=1", b.oValid, b.oLane, b.oData, b.oLast);
      else passed++;
      tick;
      total++; if (b.oIdle !== 1'b1) $display("FAIL b2b_idle got %0d exp 1", b.oIdle); else passed++;
   endtask

   task automatic test_overflow;
      b.iReady = 1'b0;
      res = '0; res[7:0] = 8'h31; drive(27'h1); tick;
      res = '0; res[39:32] = 8'h42; drive(27'h10); tick;
      res = '0; res[47:40] = 8'h55; drive(27'h20); tick;
      b.iResultValid = '0;
      total++; if (b.oOverflow !== 1'b1) $display("FAIL ovf_flag got %0d exp 1", b.oOverflow); else passed++;
      total++; if (b.oDropCount !== 16'd1) $display("FAIL ovf_cnt got %0d exp 1", b.oDropCount); else passed++;
      b.iClearOverflow = 1'b1;
      tick;
      b.iClearOverflow = 1'b0;
      total++; if (b.oOverflow !== 1'b0 || b.oDropCount !== 16'd0)
         $display("FAIL ovf_clear got flag=%0d cnt=%0d exp flag=0 cnt=0", b.oOverflow, b.oDropCount);
      else passed++;
      res = '0; res[63:56] = 8'h66; drive(27'h80);
      b.iClearOverflow = 1'b1;
      tick;
      b.iResultValid = '0; b.iClearOverflow = 1'b0;
      total++; if (b.oOverflow !== 1'b0 || b.oDropCount !== 16'd0)
         $display("FAIL ovf_clear_prio got flag=%0d cnt=%0d exp flag=0 cnt=0", b.oOverflow, b.oDropCount);
      else passed++;
      b.iReady = 1'b1;
      total++; if (b.oLane !== 5'd0 || b.oData !== 8'h31 || b.oLast !== 1'b1)
         $display("FAIL ovf_drain0 got lane=%0d data=%h last=%0d exp lane=0 data=31 last=1", b.oLane, b.oData, b.oLast);
      else passed++;
      tick;
      total++; if (b.oLane !== 5'd4 || b.oData !== 8'h42 || b.oLast !== 1'b1)
         $display("FAIL ovf_drain4 got lane=%0d data=%h last=%0d exp lane=4 data=42 last=1", b.oLane, b.oData, b.oLast);
      else passed++;
      tick;
      total++; if (b.oIdle !== 1'b1) $display("FAIL ovf_idle got %0d exp 1", b.oIdle); else passed++;
   endtask

   task automatic test_full_zero;
      b.iReady = 1'b1;
      res = '0;
      for (int k = 0; k < 27; k++) res[8*k +: 8] = 8'(k);
      drive('1);
      tick;
      b.iResultValid = '0;
      for (int k = 0; k < 27; k++) begin
         total++; if (b.oValid !== 1'b1 || b.oLane !== 5'(k) || b.oData !== 8'(k) || b.oLast !== (k == 26))
            $display("FAIL full_xfer%0d got v=%0d lane=%0d data=%0d last=%0d exp v=1 lane=%0d data=%0d last=%0d",
                     k, b.oValid, b.oLane, b.oData, b.oLast, k, k, k == 26);
         else passed++;
         tick;
      end
      total++; if (b.oValid !== 1'b0 || b.oIdle !== 1'b1)
         $display("FAIL full_end got v=%0d idle=%0d exp v=0 idle=1", b.oValid, b.oIdle);
      else passed++;
      total++; if (b.oDropCount !== 16'd0) $display("FAIL full_cnt got %0d exp 0", b.oDropCount); else passed++;
   endtask

   task automatic test_reset_mid;
      b.iReady = 1'b1;
      res = '0;
      for (int k = 0; k < 5; k++) res[8*k +: 8] = 8'h50 + 8'(k);
      drive(27'h1F);
      tick;
      b.iResultValid = '0;
      tick; tick;
      total++; if (b.oLane !== 5'd2 || b.oData !== 8'h52)
         $display("FAIL mid_lane2 got lane=%0d data=%h exp lane=2 data=52", b.oLane, b.oData);
      else passed++;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      total++; if (b.oValid !== 1'b0 || b.oIdle !== 1'b1 || b.oLane !== 5'd0 || b.oData !== 8'h00 || b.oLast !== 1'b0)
         $display("FAIL mid_rst got v=%0d idle=%0d lane=%0d data=%h last=%0d exp v=0 idle=1 lane=0 data=00 last=0",
                  b.oValid, b.oIdle, b.oLane, b.oData, b.oLast);
      else passed++;
      tick;
      total++; if (b.oValid !== 1'b0) $display("FAIL mid_norem got %0d exp 0", b.oValid); else passed++;
      res = '0; res[63:56] = 8'h77;
      drive(27'h80);
      tick;
      b.iResultValid = '0;
      total++; if (b.oLane !== 5'd7 || b.oData !== 8'h77 || b.oLast !== 1'b1)
         $display("FAIL mid_after got lane=%0d data=%h last=%0d exp lane=7 data=77 last=1", b.oLane, b.oData, b.oLast);
      else passed++;
      tick;
      total++; if (b.oIdle !== 1'b1) $display("FAIL mid_idle got %0d exp 1", b.oIdle); else passed++;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      res    = '0;
      test_reset;
      test_single;
      test_backpressure;
      test_back_to_back;
      test_overflow;
      test_full_zero;
      test_reset_mid;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
